// File: rtl/mds_tap_sched.sv
// Per-frame tap scheduler: double-buffered tap table, one entry per word slot,
// drives shift/delay/source controls of the shared bit-serial datapath.
module mds_tap_sched #(
  parameter int N_TAPS  = 8,
  parameter int WORD_W  = 24,
  parameter int SHIFT_W = 5,
  parameter int DELAY_W = 4,
  localparam int AW = $clog2(N_TAPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic               cfg_src,
  input  logic               cfg_last,
  input  logic               cfg_commit,
  output logic               commit_pending,
  output logic [SHIFT_W-1:0] shift,
  output logic [DELAY_W-1:0] delay,
  output logic               src_sel,
  output logic [AW-1:0]      tap_idx,
  output logic               tap_active,
  output logic               slot_start,
  output logic               frame_start,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FW = SHIFT_W + DELAY_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;

  logic          lr_prev;
  logic          fs;
  logic [FW-1:0] shadow_f [N_TAPS];
  logic          shadow_l [N_TAPS];
  logic [FW-1:0] active_f [N_TAPS];
  logic          active_l [N_TAPS];
  logic [FW-1:0] first_e;
  logic [FW-1:0] next_e;
  logic [AW-1:0] idx_inc;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic          in_run;
  logic          word_end;
  logic          slot_end;
  logic          is_last;

  logic [SHIFT_W-1:0] shift_n;
  logic [DELAY_W-1:0] delay_n;
  logic               src_n;
  logic [AW-1:0]      idx_n;
  logic               act_n;
  logic               slot_n;
  logic               frame_n;
  logic               ovr_n;
  logic               pend_n;

  // lrclk only counts when bclk strobes; frame start is its sampled rising edge
  assign fs       = bclk & lrclk & ~lr_prev;
  assign in_run   = (state == RUN);
  assign word_end = (bit_cnt == CW'(WORD_W - 1));
  assign slot_end = bclk & in_run & ~fs & word_end;
  assign is_last  = active_l[tap_idx] | (tap_idx == AW'(N_TAPS - 1));
  assign idx_inc  = tap_idx + 1'b1;
  assign first_e  = commit_pending ? shadow_f[0] : active_f[0];
  assign next_e   = active_f[idx_inc];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (fs)
      state_n = RUN;
    else if (slot_end && is_last)
      state_n = DONE;
  end

  always_comb begin
    shift_n   = shift;
    delay_n   = delay;
    src_n     = src_sel;
    idx_n     = tap_idx;
    act_n     = tap_active;
    bit_cnt_n = bit_cnt;
    slot_n    = 1'b0;
    frame_n   = 1'b0;
    if (fs) begin
      {src_n, delay_n, shift_n} = first_e;
      idx_n     = '0;
      bit_cnt_n = '0;
      act_n     = 1'b1;
      slot_n    = 1'b1;
      frame_n   = 1'b1;
    end else if (bclk && in_run) begin
      if (!word_end) begin
        bit_cnt_n = bit_cnt + 1'b1;
      end else if (is_last) begin
        act_n = 1'b0;
      end else begin
        {src_n, delay_n, shift_n} = next_e;
        idx_n     = idx_inc;
        bit_cnt_n = '0;
        slot_n    = 1'b1;
      end
    end
    ovr_n  = (fs & in_run) | (overrun & ~overrun_clr);
    pend_n = cfg_commit | (commit_pending & ~fs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_prev        <= 1'b0;
      shift          <= '0;
      delay          <= '0;
      src_sel        <= 1'b0;
      tap_idx        <= '0;
      tap_active     <= 1'b0;
      slot_start     <= 1'b0;
      frame_start    <= 1'b0;
      bit_cnt        <= '0;
      overrun        <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      if (bclk) lr_prev <= lrclk;
      shift          <= shift_n;
      delay          <= delay_n;
      src_sel        <= src_n;
      tap_idx        <= idx_n;
      tap_active     <= act_n;
      slot_start     <= slot_n;
      frame_start    <= frame_n;
      bit_cnt        <= bit_cnt_n;
      overrun        <= ovr_n;
      commit_pending <= pend_n;
    end
  end

  // copy reads pre-write shadow, so a same-cycle cfg_we misses this frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        shadow_f[i] <= '0;
        shadow_l[i] <= 1'b0;
        active_f[i] <= '0;
        active_l[i] <= (i == 0);
      end
    end else begin
      if (fs && commit_pending) begin
        for (int i = 0; i < N_TAPS; i++) begin
          active_f[i] <= shadow_f[i];
          active_l[i] <= shadow_l[i];
        end
      end
      if (cfg_we) begin
        shadow_f[cfg_addr] <= {cfg_src, cfg_delay, cfg_shift};
        shadow_l[cfg_addr] <= cfg_last;
      end
    end
  end

endmodule

// File: tb/tb_mds_tap_sched.sv
// Directed bench for mds_tap_sched: vector table for slot sequencing
// plus hand sequences for commit, overrun and reset corners.
module tb_mds_tap_sched;

  logic       clk;
  logic       rst_n;
  logic       bclk;
  logic       lrclk;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [4:0] cfg_shift;
  logic [3:0] cfg_delay;
  logic       cfg_src;
  logic       cfg_last;
  logic       cfg_commit;
  logic       commit_pending;
  logic [4:0] shift;
  logic [3:0] delay;
  logic       src_sel;
  logic [2:0] tap_idx;
  logic       tap_active;
  logic       slot_start;
  logic       frame_start;
  logic       overrun;
  logic       overrun_clr;

  mds_tap_sched #(
    .N_TAPS(8), .WORD_W(24), .SHIFT_W(5), .DELAY_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_shift(cfg_shift),
    .cfg_delay(cfg_delay), .cfg_src(cfg_src), .cfg_last(cfg_last),
    .cfg_commit(cfg_commit), .commit_pending(commit_pending),
    .shift(shift), .delay(delay), .src_sel(src_sel),
    .tap_idx(tap_idx), .tap_active(tap_active),
    .slot_start(slot_start), .frame_start(frame_start),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       lr;
    logic [2:0] idx;
    logic [4:0] sh;
    logic [3:0] dl;
    logic       src;
    logic       act;
    logic       slot;
  } vec_t;

  vec_t vt [14];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic lr);
    repeat (3) tick();
    bclk  = 1'b1;
    lrclk = lr;
    tick();
    bclk  = 1'b0;
  endtask

  task automatic wr(input int a, input int sh, input int dl,
                    input logic s, input logic l);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_shift = 5'(sh);
    cfg_delay = 4'(dl);
    cfg_src   = s;
    cfg_last  = l;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      repeat (vt[i].n) strobe(vt[i].lr);
      chk($sformatf("v%0d_idx", i), tap_idx, vt[i].idx);
      chk($sformatf("v%0d_shift", i), shift, vt[i].sh);
      chk($sformatf("v%0d_delay", i), delay, vt[i].dl);
      chk($sformatf("v%0d_src", i), src_sel, vt[i].src);
      chk($sformatf("v%0d_active", i), tap_active, vt[i].act);
      chk($sformatf("v%0d_slot", i), slot_start, vt[i].slot);
      chk($sformatf("v%0d_frame", i), frame_start, 0);
    end
  endtask

  initial begin
    vt[0]  = '{1,   1'b0, 3'd0, 5'd3,  4'd1,  1'b0, 1'b1, 1'b0};
    vt[1]  = '{22,  1'b0, 3'd0, 5'd3,  4'd1,  1'b0, 1'b1, 1'b0};
    vt[2]  = '{1,   1'b0, 3'd1, 5'd5,  4'd8,  1'b1, 1'b1, 1'b1};
    vt[3]  = '{24,  1'b0, 3'd2, 5'd31, 4'd15, 1'b0, 1'b1, 1'b1};
    vt[4]  = '{23,  1'b0, 3'd2, 5'd31, 4'd15, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1,   1'b0, 3'd2, 5'd31, 4'd15, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{5,   1'b0, 3'd2, 5'd31, 4'd15, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{23,  1'b1, 3'd0, 5'd0,  4'd0,  1'b0, 1'b1, 1'b0};
    vt[8]  = '{1,   1'b1, 3'd1, 5'd1,  4'd1,  1'b1, 1'b1, 1'b1};
    vt[9]  = '{24,  1'b1, 3'd2, 5'd2,  4'd2,  1'b0, 1'b1, 1'b1};
    vt[10] = '{120, 1'b1, 3'd7, 5'd7,  4'd7,  1'b1, 1'b1, 1'b1};
    vt[11] = '{23,  1'b1, 3'd7, 5'd7,  4'd7,  1'b1, 1'b1, 1'b0};
    vt[12] = '{1,   1'b1, 3'd7, 5'd7,  4'd7,  1'b1, 1'b0, 1'b0};
    vt[13] = '{20,  1'b1, 3'd7, 5'd7,  4'd7,  1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; bclk = 1'b0; lrclk = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0; cfg_delay = '0;
    cfg_src = 1'b0; cfg_last = 1'b0; cfg_commit = 1'b0;
    overrun_clr = 1'b0;
    tick(); tick();
    chk("rst_shift", shift, 0);
    chk("rst_active", tap_active, 0);
    chk("rst_pending", commit_pending, 0);
    rst_n = 1'b1;
    tick();

    // three-tap program, committed before the first frame
    wr(0, 3, 1, 1'b0, 1'b0);
    wr(1, 5, 8, 1'b1, 1'b0);
    wr(2, 31, 15, 1'b0, 1'b1);
    commit();
    chk("t1_pending_set", commit_pending, 1);
    strobe(1'b0);
    strobe(1'b1);
    chk("t1_frame", frame_start, 1);
    chk("t1_slot0", slot_start, 1);
    chk("t1_active", tap_active, 1);
    chk("t1_shift0", shift, 3);
    chk("t1_delay0", delay, 1);
    chk("t1_pending_clr", commit_pending, 0);
    apply(0, 6);

    // shadow write without commit leaves two frames unchanged
    wr(0, 9, 2, 1'b1, 1'b1);
    strobe(1'b0);
    strobe(1'b1);
    chk("t2_f1_shift", shift, 3);
    repeat (80) strobe(1'b0);
    strobe(1'b1);
    chk("t2_f2_shift", shift, 3);
    chk("t2_f2_pending", commit_pending, 0);
    commit();
    chk("t2_pending", commit_pending, 1);
    repeat (80) strobe(1'b0);
    strobe(1'b1);
    chk("t2_new_shift", shift, 9);
    chk("t2_new_delay", delay, 2);
    chk("t2_new_src", src_sel, 1);
    repeat (24) strobe(1'b0);
    chk("t2_last0_done", tap_active, 0);
    chk("t2_last0_idx", tap_idx, 0);

    // overrun: restart after 30 bclks of the three-tap list
    wr(0, 3, 1, 1'b0, 1'b0);
    commit();
    strobe(1'b0);
    strobe(1'b1);
    chk("t3_shift", shift, 3);
    chk("t3_no_ovr", overrun, 0);
    repeat (29) strobe(1'b0);
    chk("t3_idx1", tap_idx, 1);
    strobe(1'b1);
    chk("t3_ovr", overrun, 1);
    chk("t3_idx0", tap_idx, 0);
    chk("t3_frame", frame_start, 1);
    repeat (2) strobe(1'b0);
    repeat (3) tick();
    bclk = 1'b1; lrclk = 1'b1; overrun_clr = 1'b1;
    tick();
    bclk = 1'b0; overrun_clr = 1'b0;
    chk("t3_set_wins", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("t3_clr", overrun, 0);

    // commit and write landing in the frame-start cycle
    wr(0, 4, 3, 1'b0, 1'b0);
    commit();
    strobe(1'b0);
    repeat (3) tick();
    bclk = 1'b1; lrclk = 1'b1; cfg_commit = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_shift = 5'd7;
    cfg_delay = 4'd3; cfg_src = 1'b0; cfg_last = 1'b0;
    tick();
    bclk = 1'b0; cfg_commit = 1'b0; cfg_we = 1'b0;
    chk("t4_prior_shadow", shift, 4);
    chk("t4_pending", commit_pending, 1);
    repeat (5) strobe(1'b0);
    strobe(1'b1);
    chk("t4_new_shift", shift, 7);
    chk("t4_pending_clr", commit_pending, 0);
    chk("t4_ovr", overrun, 1);

    // eight taps with no last flag; lrclk stays high after frame start
    for (int i = 0; i < 8; i++) wr(i, i, i, i[0], 1'b0);
    commit();
    strobe(1'b0);
    strobe(1'b1);
    chk("t5_frame", frame_start, 1);
    chk("t5_shift0", shift, 0);
    chk("t5_idx0", tap_idx, 0);
    apply(7, 13);

    // asynchronous reset in the middle of a frame
    strobe(1'b0);
    strobe(1'b1);
    repeat (50) strobe(1'b0);
    chk("t6_running", tap_active, 1);
    chk("t6_shift2", shift, 2);
    chk("t6_ovr_pre", overrun, 1);
    commit();
    chk("t6_pending_pre", commit_pending, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_shift", shift, 0);
    chk("t6_delay", delay, 0);
    chk("t6_active", tap_active, 0);
    chk("t6_ovr", overrun, 0);
    chk("t6_pending", commit_pending, 0);
    chk("t6_idx", tap_idx, 0);
    tick(); tick();
    rst_n = 1'b1;
    strobe(1'b0);
    strobe(1'b1);
    chk("t6_fs_active", tap_active, 1);
    chk("t6_fs_shift", shift, 0);
    repeat (24) strobe(1'b0);
    chk("t6_entry0_last", tap_active, 0);
    chk("t6_entry0_idx", tap_idx, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
